// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, byte-enable width
// and the default wait-state count.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int BE_W            = 4;
  localparam int CNT_W           = 4;
  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
// The read register only updates on an enabled access, so it holds while the FSM stalls.
module dmem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [DATA_W/8-1:0]      be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one outstanding request, configurable
// wait states, byte-enabled stores and word loads, answered over a valid/ready channel.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, valid_q, err_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BE_W-1:0]    be_q;

  logic               accept, commit;
  logic               eff_we, eff_err;
  logic [ADDR_W-1:0]  eff_addr;
  logic [DATA_W-1:0]  eff_wdata;
  logic [BE_W-1:0]    eff_be;
  logic [DATA_W-1:0]  ram_rdata;

  assign accept = req_valid && ready_q;

  // With zero wait states the commit happens on the accept edge itself, so the
  // request is taken straight from the inputs; otherwise from the latch.
  always_comb begin
    eff_we    = we_q;
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    eff_be    = be_q;
    if (state_q == ST_IDLE) begin
      eff_we    = req_we;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
      eff_be    = req_be;
    end
    eff_err = (eff_addr[1:0] != 2'b00) || (eff_addr >= ADDR_W'(4 * DEPTH));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
      valid_q <= (state_d == ST_RESP);
      if (commit) begin
        err_q <= eff_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Gating the enable with reset keeps an abandoned store out of the array.
  dmem_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_array (
    .clk    (clk),
    .en_i   (commit && reset),
    .we_i   (eff_we && !eff_err),
    .be_i   (eff_be),
    .addr_i (eff_addr[AW+1:2]),
    .wdata_i(eff_wdata),
    .rdata_o(ram_rdata)
  );

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_err   = valid_q && err_q;
  assign rsp_rdata = (valid_q && !err_q && !we_q) ? ram_rdata : '0;

endmodule
